stall_mem_responder: RTL and testbench
======================================

// Module: stall_mem_responder
// PURPOSE
//  Multi-cycle word memory acting as the responder to the pipeline's memory stage
//  (and fetch, when instantiated for instructions).
//  Accepts one read or write request at a time and holds Stall high while busy.
//  Pulses Done when the access completes; DataOut carries read data.
//  Replaces the single-cycle memory so that stall/forward logic can be exercised.
// PARAMETERS
//  DEPTH_LOG2  10  number of 16-bit words = 2**DEPTH_LOG2
//  LATENCY     4   cycles from request acceptance to Done; legal range 1..15
// PORTS
//  clk      in   1   clock, posedge
//  rst      in   1   asynchronous, active-high reset
//  Rd       in   1   read request
//  Wr       in   1   write request
//  Addr     in   16  byte address; word index = Addr[DEPTH_LOG2:1]
//  DataIn   in   16  write data, sampled at acceptance
//  DataOut  out  16  read data, valid in the Done cycle, held until the next read Done
//  Stall    out  1   busy: requests presented while high are ignored
//  Done     out  1   one-cycle completion pulse
//  err      out  1   one-cycle pulse on an illegal request
// BEHAVIOUR
//  Reset: DataOut=0, Stall=0, Done=0, err=0; state=IDLE; latency counter=0.
//   Memory array contents are not cleared.
//  Reset mid-operation: the access is aborted and outputs take reset values immediately.
//   A pending write is NOT committed.
//  Acceptance: a request is accepted at posedge T when (Rd^Wr)=1, Stall=0 and state!=ERR.
//   At that edge, Addr, DataIn and the op are latched.
//  States: IDLE -> BUSY (on accept) -> DONE -> IDLE.
//   IDLE/DONE -> ERR -> IDLE on an illegal request.
//  Timing, LATENCY=L:
//   - Stall=1 for cycles T+1..T+L-1.
//   - Done=1 and Stall=0 in cycle T+L.
//   - L=1: Done at T+1, no Stall.
//  Write: the array is updated at the edge that enters DONE. DataOut is unchanged.
//  Read: DataOut is loaded from the latched word index at the edge that enters DONE.
//  Back-to-back: a new request presented during the Done cycle is accepted, since Stall=0.
//   That request's Done follows L cycles later.
//  Illegal request: Rd=1 and Wr=1 with Stall=0.
//   - err=1 in cycle T+1; no Stall, no Done, memory unchanged.
//  Rd=Wr=0: no effect.
//  Rd/Wr while Stall=1: ignored; latched fields are not disturbed.
//  Address wrap: bits above DEPTH_LOG2 are ignored, e.g. 0x0800 aliases 0x0000 at DEPTH_LOG2=10.
//  Counter: 4-bit down counter loaded with L-1 at acceptance. DONE is entered when it reaches 0.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   - Addr[0]=1 on an otherwise legal request is illegal.
//   - err=1 at T+1; no access, no Stall, no Done.
//  MEM_ALIGN_CHECK_EN undefined:
//   - Addr[0] is ignored and the access proceeds normally.
// TESTING (LATENCY=4, DEPTH_LOG2=10 unless noted)
//  1. rst=1 with random inputs -> DataOut=0x0000, Stall=0, Done=0, err=0 while reset is held.
//  2. Wr Addr=0x0010 DataIn=0x1234 at T -> Stall=1 T+1..T+3, Done=1 at T+4.
//     Then Rd 0x0010 -> DataOut=0x1234 with Done.
//  3. Rd=Wr=1 Addr=0x0020 -> err=1 at T+1 only, Stall=0, Done=0.
//     A later read of 0x0020 returns its prior value.
//  4. Wr 0x0030 <- 0xBEEF while Stall=1 from an earlier read -> ignored.
//     A read of 0x0030 returns its old contents; the earlier read still completes at T+4.
//  5. Wr 0x0040 <- 0xAAAA, then rst pulse at T+2 -> Stall/Done drop at once.
//     A read of 0x0040 after reset returns its old value.
//  6. Back-to-back and wrap:
//     - Wr 0x0800 <- 0x5A5A at T, Rd 0x0000 presented in the Done cycle (T+4)
//       -> Done at T+8 with DataOut=0x5A5A.
//     - MEM_ALIGN_CHECK_EN: Rd 0x0011 -> err at T+1, no Done.
//       Without the macro, the same read returns word 0x0010.

Source files
------------

// File: rtl/stall_mem_responder.sv
// Multi-cycle 16-bit word memory that stalls the requester for LATENCY cycles per access.
// Optional MEM_ALIGN_CHECK_EN turns odd byte addresses into illegal requests.
module stall_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic [15:0]             lat_data;
    logic                    lat_wr;
    logic [15:0]             mem [2**DEPTH_LOG2];

    logic                    misalign;
    logic                    can_take;
    logic                    accept;
    logic                    illegal;
    logic                    enter_done;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [15:0]             acc_data;
    logic                    acc_wr;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{Addr[15:DEPTH_LOG2+1], Addr[0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = Addr[0];
`else
    assign misalign = 1'b0;
`endif

    assign Stall    = (state == BUSY);
    assign Done     = (state == DONE);
    assign err      = (state == ERR);

    assign can_take = !Stall && (state != ERR);
    assign accept   = can_take && (Rd ^ Wr) && !misalign;
    assign illegal  = can_take && ((Rd && Wr) || ((Rd ^ Wr) && misalign));

    // With LATENCY=1 the access completes on the acceptance edge, so it uses the live inputs.
    assign enter_done = ((state == BUSY) && (cnt == 4'd1)) || (accept && (LATENCY == 1));
    assign acc_idx    = (state == BUSY) ? lat_idx  : Addr[DEPTH_LOG2:1];
    assign acc_data   = (state == BUSY) ? lat_data : DataIn;
    assign acc_wr     = (state == BUSY) ? lat_wr   : Wr;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches inferred.
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    cnt_n   = CNT_LOAD;
                    state_n = (LATENCY == 1) ? DONE : BUSY;
                end else if (illegal) begin
                    state_n = ERR;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = DONE;
            end
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_data <= 16'h0000;
            lat_wr   <= 1'b0;
            DataOut  <= 16'h0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_idx  <= Addr[DEPTH_LOG2:1];
                lat_data <= DataIn;
                lat_wr   <= Wr;
            end
            if (enter_done && !acc_wr) DataOut <= mem[acc_idx];
        end
    end

    // NOTE: the array has no reset (contents survive reset); rst only blocks a commit in flight.
    always_ff @(posedge clk) begin
        if (!rst && enter_done && acc_wr) mem[acc_idx] <= acc_data;
    end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed bench for stall_mem_responder: timing, scoreboarded read data, illegal, reset abort, wrap.
module tb_stall_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] Addr = 16'h0, DataIn = 16'h0;
    logic [15:0] DataOut;
    logic        Stall, Done, err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_mem [1024];
    logic [15:0] sb [$];
    logic [15:0] exp_dout = 16'h0000;

    stall_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Stall(Stall), .Done(Done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; finishes at the negedge of the Done cycle.
    task automatic op(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input string tag);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        if (rd) sb.push_back(model_mem[a[10:1]]);
        else    model_mem[a[10:1]] = d;
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            check({tag, " stall"}, 16'(Stall), 16'd1);
            check({tag, " no_done"}, 16'(Done), 16'd0);
        end
        @(negedge clk);
        check({tag, " done"}, 16'(Done), 16'd1);
        check({tag, " stall_low"}, 16'(Stall), 16'd0);
        if (rd && sb.size() > 0) exp_dout = sb.pop_front();
        check({tag, " dout"}, DataOut, exp_dout);
    endtask

    task automatic bad_req(input logic rd, input logic wr, input logic [15:0] a, input string tag);
        Rd = rd; Wr = wr; Addr = a; DataIn = 16'hDEAD;
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        check({tag, " err"}, 16'(err), 16'd1);
        check({tag, " stall"}, 16'(Stall), 16'd0);
        check({tag, " done"}, 16'(Done), 16'd0);
        @(negedge clk);
        check({tag, " err_pulse"}, 16'(err), 16'd0);
        check({tag, " done_after"}, 16'(Done), 16'd0);
    endtask

    initial begin
        // 1. reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            Rd = 1'($urandom); Wr = 1'($urandom);
            Addr = 16'($urandom); DataIn = 16'($urandom);
            @(negedge clk);
            check("rst dout", DataOut, 16'h0000);
            check("rst stall", 16'(Stall), 16'd0);
            check("rst done", 16'(Done), 16'd0);
            check("rst err", 16'(err), 16'd0);
        end
        Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        rst = 1'b0;
        @(negedge clk);

        op(1'b0, 1'b1, 16'h0020, 16'h1111, "pre20");
        op(1'b0, 1'b1, 16'h0030, 16'h2222, "pre30");
        op(1'b0, 1'b1, 16'h0040, 16'h3333, "pre40");

        // 2. write then read back
        op(1'b0, 1'b1, 16'h0010, 16'h1234, "wr10");
        op(1'b1, 1'b0, 16'h0010, 16'h0000, "rd10");

        // 3. illegal Rd&Wr leaves memory untouched
        bad_req(1'b1, 1'b1, 16'h0020, "ill20");
        op(1'b1, 1'b0, 16'h0020, 16'h0000, "rd20");

        // 4. write presented while stalled is ignored
        Rd = 1'b1; Addr = 16'h0030;
        sb.push_back(model_mem[16'h0030 >> 1]);
        @(posedge clk); #1;
        Rd = 1'b0;
        @(negedge clk);
        check("ign stall1", 16'(Stall), 16'd1);
        Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hBEEF;
        @(posedge clk); #1;
        Wr = 1'b0;
        @(negedge clk);
        check("ign stall2", 16'(Stall), 16'd1);
        @(negedge clk);
        check("ign stall3", 16'(Stall), 16'd1);
        @(negedge clk);
        check("ign done", 16'(Done), 16'd1);
        if (sb.size() > 0) exp_dout = sb.pop_front();
        check("ign dout", DataOut, exp_dout);
        op(1'b1, 1'b0, 16'h0030, 16'h0000, "rd30");

        // 5. reset mid-write aborts it
        Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hAAAA;
        @(posedge clk); #1;
        Wr = 1'b0;
        @(negedge clk);
        check("abort stall", 16'(Stall), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_dout = 16'h0000;
        check("abort stall_low", 16'(Stall), 16'd0);
        check("abort done", 16'(Done), 16'd0);
        check("abort dout", DataOut, exp_dout);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(1'b1, 1'b0, 16'h0040, 16'h0000, "rd40");

        // 6. wrap alias, read issued in the Done cycle of the write
        op(1'b0, 1'b1, 16'h0800, 16'h5A5A, "wr800");
        op(1'b1, 1'b0, 16'h0000, 16'h0000, "rd000");

`ifdef MEM_ALIGN_CHECK_EN
        bad_req(1'b1, 1'b0, 16'h0011, "align11");
`else
        op(1'b1, 1'b0, 16'h0011, 16'h0000, "rd11");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
